// File: rtl/store_buffer_pkg.sv
// Shared memory-access types for the store buffer and the array it drives.
// Holds the access-size enum, the buffered-entry record and the word compare.
package store_buffer_pkg;

    localparam int SB_DEPTH = 4;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'b00,
        MEM_HALF = 2'b01,
        MEM_WORD = 2'b10
    } mem_access_size_t;

    typedef struct packed {
        logic [31:0]      addr;
        logic [31:0]      data;
        mem_access_size_t size;
    } store_buffer_entry_t;

    // True when both byte addresses fall in the same aligned 32-bit word.
    function automatic logic word_match(input logic [31:0] a, input logic [31:0] b);
        return ((a ^ b) & 32'hFFFF_FFFC) == 32'h0;
    endfunction

endpackage

// File: rtl/memory_array_interface.sv
// Write/read port bundle of the memory array; the array commits writes on the
// clock edge and answers reads combinationally.
interface memory_array_interface;
    import store_buffer_pkg::*;

    logic             wr_enable;
    logic [31:0]      wr_addr;
    logic [31:0]      wr_data;
    mem_access_size_t wr_size;
    logic [31:0]      rd_addr;
    mem_access_size_t rd_size;
    logic [31:0]      rd_data;

    modport master (
        output wr_enable, wr_addr, wr_data, wr_size,
        output rd_addr, rd_size,
        input  rd_data
    );

    modport slave (
        input  wr_enable, wr_addr, wr_data, wr_size,
        input  rd_addr, rd_size,
        output rd_data
    );

endinterface

// File: rtl/store_buffer.sv
// In-order store FIFO draining one entry per cycle into the memory array, with
// loads passed straight through and stalled while any buffered store hits their word.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  st_valid_i,
    output logic                  st_ready_o,
    input  logic [31:0]           st_addr_i,
    input  logic [31:0]           st_data_i,
    input  mem_access_size_t      st_size_i,
    input  logic                  ld_valid_i,
    output logic                  ld_ready_o,
    input  logic [31:0]           ld_addr_i,
    input  mem_access_size_t      ld_size_i,
    output logic [31:0]           ld_data_o,
    input  logic                  drain_req_i,
    output logic                  empty_o,
    memory_array_interface.master mem
);

    localparam int PTR_W = $clog2(DEPTH);

    store_buffer_entry_t r_entries [DEPTH];
    logic [PTR_W-1:0]    r_head;
    logic [PTR_W-1:0]    r_tail;
    logic [PTR_W:0]      r_count;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic                w_hazard;
    logic [DEPTH-1:0]    w_entry_valid;

    assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
    assign w_empty = (r_count == '0);

    // A pop in the same cycle never frees a slot for a push: full means not ready.
    assign st_ready_o = ~w_full & ~drain_req_i;
    assign w_push     = st_valid_i & st_ready_o;
    assign w_pop      = ~w_empty;
    assign empty_o    = w_empty;

    assign mem.wr_enable = w_pop;
    assign mem.wr_addr   = r_entries[r_head].addr;
    assign mem.wr_data   = r_entries[r_head].data;
    assign mem.wr_size   = r_entries[r_head].size;

    assign mem.rd_addr = ld_addr_i;
    assign mem.rd_size = ld_size_i;
    assign ld_data_o   = mem.rd_data;

    // An entry is live when its distance from head is below the occupancy.
    for (genvar g = 0; g < DEPTH; g++) begin : g_valid
        logic [PTR_W-1:0] w_offset;
        assign w_offset         = PTR_W'(g) - r_head;
        assign w_entry_valid[g] = ({1'b0, w_offset} < r_count);
    end

    // The head entry draining this cycle still blocks loads: there is no forwarding.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        w_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_entry_valid[i] && word_match(r_entries[i].addr, ld_addr_i)) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign ld_ready_o = ~w_hazard;

    // NOTE: the entry storage has no reset; occupancy alone decides which slots are live.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_entries[r_tail] <= '{addr: st_addr_i, data: st_data_i, size: st_size_i};
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    logic w_unused;
    assign w_unused = ld_valid_i;

endmodule
